// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus bundle.
// master: the control unit. It takes the memory hit strobes, the IR fields
//         and the ALU flags, and it drives every datapath enable and select,
//         plus the status outputs halt, timeout_err, state and retired.
// slave : the datapath/arbiter side, with the opposite directions.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero_flag;
  logic             over_flag;
  logic             iren;
  logic             dren;
  logic             dwen;
  logic             irwen;
  logic             pcwen;
  logic [1:0]       pcsrc;
  logic             regW;
  logic [1:0]       regDest;
  logic [1:0]       memToReg;
  logic [1:0]       aluSrc;
  logic [1:0]       extSel;
  logic [3:0]       aluop;
  logic             halt;
  logic             timeout_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  ihit, dhit, opcode, funct, zero_flag, over_flag,
    output iren, dren, dwen, irwen, pcwen, pcsrc, regW, regDest, memToReg,
           aluSrc, extSel, aluop, halt, timeout_err, state, retired
  );

  modport slave (
    output ihit, dhit, opcode, funct, zero_flag, over_flag,
    input  iren, dren, dwen, irwen, pcwen, pcsrc, regW, regDest, memToReg,
           aluSrc, extSel, aluop, halt, timeout_err, state, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit. It sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives all of the datapath enables.
// Ports: CLK, nRST (async active-low), bus (master modport of
//        multicycle_control_unit_if; holds the handshakes, the IR fields,
//        the ALU flags, the enables/selects and the status outputs).
//
// state  | meaning
// FETCH  | request instruction, latch IR on ihit
// DECODE | resolve jumps/halt/illegal, else go to EXEC
// EXEC   | ALU operation, branch/JR resolution
// MEM    | data read/write, wait for dhit
// WB     | register write-back, retire
// HALTED | absorbing stop until reset
module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0,
  parameter int OVF_TRAP    = 1
) (
  input logic                    CLK,
  input logic                    nRST,
  multicycle_control_unit_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                         OP_SW    = 6'h2B, OP_HALT = 6'h3F;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
  localparam logic [3:0] ALU_ADD = 4'd2, ALU_SUB = 4'd3;

  // The counter only has to reach MEM_TIMEOUT-1; the waiting cycle that would
  // take it to MEM_TIMEOUT is the one that trips the watchdog.
  localparam int WD_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int WD_LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIM);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_limit, wd_fire, timeout_q;
  logic [CNT_W-1:0] retired_q;
  logic             is_r, r_ok, op_ok, trap_op;

  always_comb begin
    is_r    = (bus.opcode == OP_RTYPE);
    r_ok    = (bus.funct == F_JR) || (bus.funct == F_ADD) ||
              (bus.funct == F_ADDU) || (bus.funct == F_SUB);
    op_ok   = is_r ? r_ok :
              (bus.opcode inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
                                  OP_ADDIU, OP_LUI, OP_LW, OP_SW, OP_HALT});
    trap_op = (is_r && ((bus.funct == F_ADD) || (bus.funct == F_SUB))) ||
              (bus.opcode == OP_ADDI);
    wd_limit = (MEM_TIMEOUT > 0) && (wd_cnt == WD_LAST);
  end

  always_comb begin
    state_d      = state_q;
    wd_fire      = 1'b0;
    bus.iren     = 1'b0;
    bus.dren     = 1'b0;
    bus.dwen     = 1'b0;
    bus.irwen    = 1'b0;
    bus.pcwen    = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.regW     = 1'b0;
    bus.regDest  = 2'b00;
    bus.memToReg = 2'b00;
    bus.aluSrc   = 2'b00;
    bus.extSel   = 2'b00;
    bus.aluop    = 4'd0;
    bus.halt     = 1'b0;
    case (state_q)
      FETCH: begin
        bus.iren = 1'b1;
        if (bus.ihit) begin
          bus.irwen = 1'b1;
          state_d   = DECODE;
        end else if (wd_limit) begin
          wd_fire = 1'b1;
          state_d = HALTED;
        end
      end
      DECODE: begin
        if (bus.opcode == OP_HALT) begin
          state_d = HALTED;
        end else if (bus.opcode == OP_J) begin
          bus.pcwen = 1'b1;
          bus.pcsrc = 2'b10;
          state_d   = FETCH;
        end else if (bus.opcode == OP_JAL) begin
          bus.regW     = 1'b1;
          bus.regDest  = 2'b10;
          bus.memToReg = 2'b10;
          bus.pcwen    = 1'b1;
          bus.pcsrc    = 2'b10;
          state_d      = FETCH;
        end else if (!op_ok) begin
          // Illegal encodings retire as a NOP so the program keeps moving.
          bus.pcwen = 1'b1;
          state_d   = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (bus.opcode)
          OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
            bus.aluSrc = 2'b01;
            bus.extSel = 2'b01;
            bus.aluop  = ALU_ADD;
          end
          OP_LUI: begin
            bus.aluSrc = 2'b10;
            bus.aluop  = ALU_ADD;
          end
          OP_BEQ, OP_BNE: begin
            bus.extSel = 2'b01;
            bus.aluop  = ALU_SUB;
          end
          default: bus.aluop = (bus.funct == F_SUB) ? ALU_SUB : ALU_ADD;
        endcase
        if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) begin
          bus.pcwen = 1'b1;
          if ((bus.opcode == OP_BEQ) == bus.zero_flag) bus.pcsrc = 2'b01;
          state_d = FETCH;
        end else if (is_r && (bus.funct == F_JR)) begin
          bus.pcwen = 1'b1;
          bus.pcsrc = 2'b11;
          state_d   = FETCH;
        end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        bus.dren = (bus.opcode == OP_LW);
        bus.dwen = (bus.opcode == OP_SW);
        if (bus.dhit) begin
          if (bus.opcode == OP_LW) begin
            state_d = WB;
          end else begin
            bus.pcwen = 1'b1;
            state_d   = FETCH;
          end
        end else if (wd_limit) begin
          wd_fire = 1'b1;
          state_d = HALTED;
        end
      end
      WB: begin
        bus.regW     = !((OVF_TRAP != 0) && trap_op && bus.over_flag);
        bus.memToReg = (bus.opcode == OP_LW) ? 2'b01 : 2'b00;
        bus.regDest  = is_r ? 2'b01 : 2'b00;
        bus.pcwen    = 1'b1;
        state_d      = FETCH;
      end
      HALTED:  bus.halt = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= FETCH;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      // Staying put in FETCH/MEM means a wait cycle; any move re-arms the count.
      if ((state_d != state_q) || ((state_q != FETCH) && (state_q != MEM)))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_fire) timeout_q <= 1'b1;
      if (bus.pcwen) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.state       = state_q;
  assign bus.timeout_err = timeout_q;
  assign bus.retired     = retired_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, zero_flag, over_flag;
  logic [5:0] opcode, funct;
  int         tests = 0;
  int         fails = 0;
  int         exp_ret = 0;

  always #5 CLK = ~CLK;

  multicycle_control_unit_if #(.CNT_W(32)) bus0();
  multicycle_control_unit_if #(.CNT_W(32)) bus1();

  assign bus0.ihit = ihit;       assign bus1.ihit = ihit;
  assign bus0.dhit = dhit;       assign bus1.dhit = dhit;
  assign bus0.opcode = opcode;   assign bus1.opcode = opcode;
  assign bus0.funct = funct;     assign bus1.funct = funct;
  assign bus0.zero_flag = zero_flag; assign bus1.zero_flag = zero_flag;
  assign bus0.over_flag = over_flag; assign bus1.over_flag = over_flag;

  // dut0: watchdog at 8, overflow trap on. dut1: no watchdog, no trap.
  multicycle_control_unit #(.CNT_W(32), .MEM_TIMEOUT(8), .OVF_TRAP(1)) dut0 (
    .CLK(CLK), .nRST(nRST), .bus(bus0));
  multicycle_control_unit #(.CNT_W(32), .MEM_TIMEOUT(0), .OVF_TRAP(0)) dut1 (
    .CLK(CLK), .nRST(nRST), .bus(bus1));

  task automatic test_reset;
    @(negedge CLK); #1;
    tests++; if (bus0.state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", bus0.state); end
    tests++; if (bus0.iren !== 1'b1) begin fails++; $display("FAIL reset_iren got %0b exp 1", bus0.iren); end
    tests++; if (bus0.retired !== 32'd0) begin fails++; $display("FAIL reset_retired got %0d exp 0", bus0.retired); end
    tests++; if ({bus0.halt, bus0.timeout_err} !== 2'b00) begin fails++; $display("FAIL reset_status got %b exp 00", {bus0.halt, bus0.timeout_err}); end
    tests++; if ({bus0.dren, bus0.dwen, bus0.irwen, bus0.pcwen, bus0.regW} !== 5'b0) begin fails++; $display("FAIL reset_enables got %b exp 00000", {bus0.dren, bus0.dwen, bus0.irwen, bus0.pcwen, bus0.regW}); end
    tests++; if ({bus0.pcsrc, bus0.regDest, bus0.memToReg, bus0.aluSrc, bus0.extSel, bus0.aluop} !== 14'b0) begin fails++; $display("FAIL reset_selects got %h exp 0", {bus0.pcsrc, bus0.regDest, bus0.memToReg, bus0.aluSrc, bus0.extSel, bus0.aluop}); end
    @(negedge CLK);
    nRST = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_addu;
    logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic       exp_pw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'h00; funct = 6'h21; ihit = 1'b1; over_flag = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (bus0.state !== exp_st[c]) begin fails++; $display("FAIL addu_state c%0d got %0d exp %0d", c, bus0.state, exp_st[c]); end
      if (c < 4) begin
        tests++; if (bus0.pcwen !== exp_pw[c]) begin fails++; $display("FAIL addu_pcwen c%0d got %0b exp %0b", c, bus0.pcwen, exp_pw[c]); end
      end
      if (c == 3) begin
        tests++; if ({bus0.regW, bus0.regDest} !== 3'b101) begin fails++; $display("FAIL addu_wb got %b exp 101", {bus0.regW, bus0.regDest}); end
        exp_ret++;
      end
      if (c == 4) begin
        tests++; if (bus0.retired !== exp_ret) begin fails++; $display("FAIL addu_retired got %0d exp %0d", bus0.retired, exp_ret); end
      end else @(negedge CLK);
    end
  endtask

  task automatic test_lw;
    int n_dren = 0, mem_seen = 0, cycles = 0;
    bit done = 0;
    logic [2:0] st;
    opcode = 6'h23; funct = 6'h00; ihit = 1'b1; dhit = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      st = bus0.state;
      if (c > 0 && st == 3'd0) done = 1;
      else begin
        if (st == 3'd3) begin dhit = (mem_seen == 2); mem_seen++; end
        else dhit = 1'b0;
        #1;
        if (bus0.dren) n_dren++;
        if (st == 3'd4) begin
          tests++; if ({bus0.regW, bus0.memToReg, bus0.regDest} !== 5'b10100) begin fails++; $display("FAIL lw_wb got %b exp 10100", {bus0.regW, bus0.memToReg, bus0.regDest}); end
        end
        cycles++;
        @(negedge CLK);
      end
    end
    dhit = 1'b0;
    exp_ret++;
    tests++; if (!done) begin fails++; $display("FAIL lw_timeout got %0d cycles exp return to FETCH", cycles); end
    tests++; if (n_dren !== 3) begin fails++; $display("FAIL lw_dren_cycles got %0d exp 3", n_dren); end
    tests++; if (cycles !== 7) begin fails++; $display("FAIL lw_latency got %0d exp 7", cycles); end
    tests++; if (bus0.retired !== exp_ret) begin fails++; $display("FAIL lw_retired got %0d exp %0d", bus0.retired, exp_ret); end
  endtask

  task automatic test_branch;
    logic [5:0] ops [2] = '{6'h04, 6'h05};
    logic [1:0] exp_src [2] = '{2'b01, 2'b00};
    ihit = 1'b1; zero_flag = 1'b1; funct = 6'h00;
    for (int v = 0; v < 2; v++) begin
      opcode = ops[v];
      for (int c = 0; c < 3; c++) begin
        #1;
        if (c == 2) begin
          tests++; if (bus0.state !== 3'd2) begin fails++; $display("FAIL br%0d_state got %0d exp 2", v, bus0.state); end
          tests++; if ({bus0.pcwen, bus0.pcsrc} !== {1'b1, exp_src[v]}) begin fails++; $display("FAIL br%0d_pc got %b exp %b", v, {bus0.pcwen, bus0.pcsrc}, {1'b1, exp_src[v]}); end
        end
        @(negedge CLK);
      end
      exp_ret++;
    end
    zero_flag = 1'b0;
    #1;
    tests++; if (bus0.state !== 3'd0) begin fails++; $display("FAIL br_end_state got %0d exp 0", bus0.state); end
    tests++; if (bus0.retired !== exp_ret) begin fails++; $display("FAIL br_retired got %0d exp %0d", bus0.retired, exp_ret); end
  endtask

  task automatic test_ovf;
    logic [5:0] fns [2] = '{6'h20, 6'h21};
    logic       exp_w0 [2] = '{1'b0, 1'b1};
    opcode = 6'h00; ihit = 1'b1; over_flag = 1'b1;
    for (int v = 0; v < 2; v++) begin
      funct = fns[v];
      for (int c = 0; c < 4; c++) begin
        #1;
        if (c == 3) begin
          tests++; if ({bus0.regW, bus0.pcwen} !== {exp_w0[v], 1'b1}) begin fails++; $display("FAIL ovf%0d_trap got %b exp %b", v, {bus0.regW, bus0.pcwen}, {exp_w0[v], 1'b1}); end
          tests++; if ({bus1.regW, bus1.pcwen} !== 2'b11) begin fails++; $display("FAIL ovf%0d_notrap got %b exp 11", v, {bus1.regW, bus1.pcwen}); end
        end
        @(negedge CLK);
      end
      exp_ret++;
    end
    over_flag = 1'b0;
    #1;
    tests++; if (bus0.retired !== exp_ret) begin fails++; $display("FAIL ovf_retired got %0d exp %0d", bus0.retired, exp_ret); end
  endtask

  // Seven idle FETCH cycles, then ihit on the cycle the limit is reached.
  task automatic test_watchdog_boundary;
    opcode = 6'h02; funct = 6'h00;
    for (int c = 0; c < 8; c++) begin
      ihit = (c == 7);
      #1;
      if (c == 7) begin
        tests++; if (bus0.irwen !== 1'b1) begin fails++; $display("FAIL wdb_irwen got %0b exp 1", bus0.irwen); end
      end
      @(negedge CLK);
    end
    #1;
    tests++; if ({bus0.state, bus0.timeout_err} !== {3'd1, 1'b0}) begin fails++; $display("FAIL wdb_decode got %b exp 0010", {bus0.state, bus0.timeout_err}); end
    tests++; if ({bus0.pcwen, bus0.pcsrc} !== 3'b110) begin fails++; $display("FAIL wdb_jump got %b exp 110", {bus0.pcwen, bus0.pcsrc}); end
    @(negedge CLK);
    exp_ret++;
    #1;
    tests++; if ({bus0.state, bus0.retired} !== {3'd0, exp_ret[31:0]}) begin fails++; $display("FAIL wdb_retire got %0d/%0d exp 0/%0d", bus0.state, bus0.retired, exp_ret); end
  endtask

  task automatic test_watchdog;
    int fetch_cycles = 0;
    bit hit_halt = 0;
    ihit = 1'b0;
    for (int c = 0; c < 20 && !hit_halt; c++) begin
      #1;
      if (bus0.state == 3'd5) hit_halt = 1;
      else begin
        fetch_cycles++;
        @(negedge CLK);
      end
    end
    tests++; if (!hit_halt) begin fails++; $display("FAIL wd_no_halt got state %0d exp 5", bus0.state); end
    tests++; if (fetch_cycles !== 8) begin fails++; $display("FAIL wd_cycles got %0d exp 8", fetch_cycles); end
    tests++; if ({bus0.halt, bus0.timeout_err, bus0.iren} !== 3'b110) begin fails++; $display("FAIL wd_status got %b exp 110", {bus0.halt, bus0.timeout_err, bus0.iren}); end
    tests++; if (bus0.retired !== exp_ret) begin fails++; $display("FAIL wd_retired got %0d exp %0d", bus0.retired, exp_ret); end
    tests++; if ({bus1.state, bus1.timeout_err} !== 4'b0000) begin fails++; $display("FAIL wd_disabled got %b exp 0000", {bus1.state, bus1.timeout_err}); end
  endtask

  task automatic test_reset_mid;
    nRST = 1'b0; #1; nRST = 1'b1;
    exp_ret = 0;
    @(negedge CLK);
    opcode = 6'h2B; funct = 6'h00; ihit = 1'b1; dhit = 1'b0;
    for (int c = 0; c < 3; c++) @(negedge CLK);
    #1;
    tests++; if ({bus0.state, bus0.dwen} !== {3'd3, 1'b1}) begin fails++; $display("FAIL rst_sw_mem got %b exp 0111", {bus0.state, bus0.dwen}); end
    #1; nRST = 1'b0; #1;
    tests++; if ({bus0.state, bus0.dwen, bus0.pcwen, bus0.regW} !== 6'b000000) begin fails++; $display("FAIL rst_async got %b exp 000000", {bus0.state, bus0.dwen, bus0.pcwen, bus0.regW}); end
    tests++; if ({bus0.retired, bus0.timeout_err} !== 33'd0) begin fails++; $display("FAIL rst_clear got %0d/%0b exp 0/0", bus0.retired, bus0.timeout_err); end
    @(negedge CLK);
    nRST = 1'b1;
    opcode = 6'h00; funct = 6'h21;
    for (int c = 0; c < 4; c++) @(negedge CLK);
    exp_ret++;
    #1;
    tests++; if ({bus0.state, bus0.retired} !== {3'd0, exp_ret[31:0]}) begin fails++; $display("FAIL rst_resume got %0d/%0d exp 0/%0d", bus0.state, bus0.retired, exp_ret); end
  endtask

  task automatic test_halt_op;
    opcode = 6'h3F; funct = 6'h00; ihit = 1'b1;
    @(negedge CLK);
    #1;
    tests++; if ({bus0.state, bus0.pcwen} !== {3'd1, 1'b0}) begin fails++; $display("FAIL halt_decode got %b exp 0010", {bus0.state, bus0.pcwen}); end
    for (int c = 0; c < 4; c++) @(negedge CLK);
    #1;
    tests++; if ({bus0.state, bus0.halt, bus0.timeout_err, bus0.iren} !== {3'd5, 3'b100}) begin fails++; $display("FAIL halt_absorb got %b exp 101100", {bus0.state, bus0.halt, bus0.timeout_err, bus0.iren}); end
    tests++; if (bus0.retired !== exp_ret) begin fails++; $display("FAIL halt_retired got %0d exp %0d", bus0.retired, exp_ret); end
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; zero_flag = 1'b0; over_flag = 1'b0;
    opcode = 6'h00; funct = 6'h00;
    test_reset;
    test_addu;
    test_lw;
    test_branch;
    test_ovf;
    test_watchdog_boundary;
    test_watchdog;
    test_reset_mid;
    test_halt_op;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got time %0t exp finish earlier", $time);
    $fatal(1, "time limit");
  end
endmodule
